branch_resolve: RTL

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// Branch resolution unit: in-flight prediction FIFO, redirect on mispredict, predictor training.
// Optional saturating statistics counters are enabled by defining BRANCH_RESOLVE_STATS_EN.
module branch_resolve #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pred_valid,
   input  logic [31:0] pred_pc,
   input  logic        pred_taken,
   input  logic        pred_lpredict,
   input  logic        pred_gpredict,
   output logic        pred_ready,
   input  logic        res_valid,
   input  logic        res_taken,
   input  logic [31:0] res_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic        upd_valid,
   output logic [31:0] upd_pc,
   output logic        upd_taken,
   output logic        upd_lcorrect,
   output logic        upd_gcorrect,
   output logic        err_underflow,
   output logic [15:0] stat_branches,
   output logic [15:0] stat_mispred
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      ACTIVE  = 1'b0,
      RECOVER = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;

   // Record layout: {pc[31:0], taken, lpredict, gpredict}
   logic [34:0] fifo_mem [DEPTH];
   logic [34:0] head;

   logic        empty, full, pop, push, mis_now;
   logic [31:0] redirect_d;

   logic        mispredict_q, upd_valid_q, upd_taken_q, upd_lcorrect_q, upd_gcorrect_q;
   logic        err_underflow_q;
   logic [31:0] redirect_pc_q, upd_pc_q;

   assign head  = fifo_mem[rd_ptr_q[AW-1:0]];
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign pop     = res_valid && !empty && (state_q == ACTIVE);
   assign mis_now = pop && (head[2] != res_taken);
   // A pop frees a slot in the same cycle, so a full queue can still take a push.
   assign pred_ready = (!full || pop) && (state_q == ACTIVE) && !mis_now;
   assign push       = pred_valid && pred_ready;

   assign redirect_d = res_taken ? res_target : (head[34:3] + 32'd4);

   always_comb begin
      state_d  = ACTIVE;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (mis_now) begin
         // Squash everything younger than the mispredicted branch.
         wr_ptr_d = rd_ptr_q + 1'b1;
         state_d  = RECOVER;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q[AW-1:0]] <= {pred_pc, pred_taken, pred_lpredict, pred_gpredict};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ACTIVE;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         mispredict_q    <= 1'b0;
         upd_valid_q     <= 1'b0;
         upd_taken_q     <= 1'b0;
         upd_lcorrect_q  <= 1'b0;
         upd_gcorrect_q  <= 1'b0;
         err_underflow_q <= 1'b0;
         redirect_pc_q   <= '0;
         upd_pc_q        <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         upd_valid_q  <= pop;
         mispredict_q <= mis_now;
         if (pop) begin
            upd_pc_q       <= head[34:3];
            upd_taken_q    <= res_taken;
            upd_lcorrect_q <= (head[1] == res_taken);
            upd_gcorrect_q <= (head[0] == res_taken);
            redirect_pc_q  <= redirect_d;
         end
         if (res_valid && !pop) begin
            err_underflow_q <= 1'b1;
         end
      end
   end

   assign mispredict    = mispredict_q;
   assign redirect_pc   = redirect_pc_q;
   assign upd_valid     = upd_valid_q;
   assign upd_pc        = upd_pc_q;
   assign upd_taken     = upd_taken_q;
   assign upd_lcorrect  = upd_lcorrect_q;
   assign upd_gcorrect  = upd_gcorrect_q;
   assign err_underflow = err_underflow_q;

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [15:0] stat_branches_q, stat_mispred_q;

   // Counted on the pop edge so the counts move together with upd_valid/mispredict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches_q <= '0;
         stat_mispred_q  <= '0;
      end else begin
         if (pop && (stat_branches_q != 16'hFFFF)) begin
            stat_branches_q <= stat_branches_q + 16'd1;
         end
         if (mis_now && (stat_mispred_q != 16'hFFFF)) begin
            stat_mispred_q <= stat_mispred_q + 16'd1;
         end
      end
   end

   assign stat_branches = stat_branches_q;
   assign stat_mispred  = stat_mispred_q;
`else
   assign stat_branches = 16'd0;
   assign stat_mispred  = 16'd0;
`endif

endmodule
